// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing
// and a saturating count of inserted bubble cycles.
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic [4:0]        IF_ID_RegisterRd,
  input  logic [8:0]        ID_Ctrl,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExtImm,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic [8:0]        ID_EX_Ctrl,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_SignExtImm,
  output logic [4:0]        ID_EX_RegisterRs,
  output logic [4:0]        ID_EX_RegisterRt,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic [CNT_W-1:0]  StallCount
);

  logic stall;
  logic bubble;
  logic countEn;

  // A load in EX whose destination is a source of the ID instruction cannot
  // be forwarded in time; $0 is never a real dependency.
  assign stall = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                 ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                  (ID_EX_RegisterRt == IF_ID_RegisterRt));

  assign bubble      = Flush || stall;
  assign PCWrite     = !stall || Flush;
  assign IF_ID_Write = !stall || Flush;
  assign countEn     = stall && !Flush && (StallCount != {CNT_W{1'b1}});

  assign ID_EX_RegWrite = ID_EX_Ctrl[8];
  assign ID_EX_MemRead  = ID_EX_Ctrl[6];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_Ctrl       <= '0;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExtImm <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
    end else if (bubble) begin
      // Zeroed specifiers keep the forwarding unit from matching on a bubble.
      ID_EX_Ctrl       <= '0;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExtImm <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
    end else begin
      ID_EX_Ctrl       <= ID_Ctrl;
      ID_EX_ReadData1  <= ID_ReadData1;
      ID_EX_ReadData2  <= ID_ReadData2;
      ID_EX_SignExtImm <= ID_SignExtImm;
      ID_EX_RegisterRs <= IF_ID_RegisterRs;
      ID_EX_RegisterRt <= IF_ID_RegisterRt;
      ID_EX_RegisterRd <= IF_ID_RegisterRd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (countEn) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed scenarios followed by
// randomized instruction streams compared against an EX-stage content model.
module tb_id_ex_hazard_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Flush;
  logic [4:0]    IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd;
  logic [8:0]    ID_Ctrl;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm;
  logic          PCWrite, IF_ID_Write;
  logic [8:0]    ID_EX_Ctrl;
  logic          ID_EX_RegWrite, ID_EX_MemRead;
  logic [DW-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic [4:0]    ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic [CW-1:0] StallCount;

  id_ex_hazard_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_RegisterRd(IF_ID_RegisterRd), .ID_Ctrl(ID_Ctrl),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_SignExtImm(ID_SignExtImm), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_SignExtImm(ID_EX_SignExtImm),
    .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct packed {
    logic [8:0]    ctrl;
    logic [DW-1:0] d1, d2, imm;
    logic [4:0]    rs, rt, rd;
  } exInstT;

  exInstT exModel;
  int     stallModel;
  int     vectors;
  int     miscompares;
  localparam logic [8:0] LW_CTRL = 9'h1C4;  // RegWrite, MemtoReg, MemRead, ALUSrc

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkEx(input string tag);
    check({tag, ".ctrl"}, 64'(ID_EX_Ctrl), 64'(exModel.ctrl));
    check({tag, ".regwrite"}, 64'(ID_EX_RegWrite), 64'(exModel.ctrl[8]));
    check({tag, ".memread"}, 64'(ID_EX_MemRead), 64'(exModel.ctrl[6]));
    check({tag, ".rd1"}, 64'(ID_EX_ReadData1), 64'(exModel.d1));
    check({tag, ".rd2"}, 64'(ID_EX_ReadData2), 64'(exModel.d2));
    check({tag, ".imm"}, 64'(ID_EX_SignExtImm), 64'(exModel.imm));
    check({tag, ".rs"}, 64'(ID_EX_RegisterRs), 64'(exModel.rs));
    check({tag, ".rt"}, 64'(ID_EX_RegisterRt), 64'(exModel.rt));
    check({tag, ".rd"}, 64'(ID_EX_RegisterRd), 64'(exModel.rd));
    check({tag, ".stallcount"}, 64'(StallCount), 64'(stallModel));
  endtask

  // One pipeline cycle: present an ID instruction, check the hazard outputs
  // before the edge, then check what EX holds after it.
  task automatic step(input string tag, input logic fl, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [8:0] ct,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic [DW-1:0] imm);
    bit dependsOnLoad;
    @(negedge clk);
    Flush = fl; IF_ID_RegisterRs = rs; IF_ID_RegisterRt = rt; IF_ID_RegisterRd = rd;
    ID_Ctrl = ct; ID_ReadData1 = d1; ID_ReadData2 = d2; ID_SignExtImm = imm;
    #1;
    dependsOnLoad = exModel.ctrl[6] && exModel.rt != 0 &&
                    (exModel.rt == rs || exModel.rt == rt);
    check({tag, ".pcwrite"}, 64'(PCWrite), 64'(!dependsOnLoad || fl));
    check({tag, ".ifidwrite"}, 64'(IF_ID_Write), 64'(!dependsOnLoad || fl));
    @(posedge clk);
    if (dependsOnLoad && !fl) stallModel = (stallModel < 15) ? stallModel + 1 : 15;
    if (fl || dependsOnLoad) exModel = '0;
    else exModel = '{ctrl: ct, d1: d1, d2: d2, imm: imm, rs: rs, rt: rt, rd: rd};
    #1;
    checkEx(tag);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    exModel = '0; stallModel = 0;
    rst_n = 1'b0; Flush = 1'b0;
    IF_ID_RegisterRs = '0; IF_ID_RegisterRt = '0; IF_ID_RegisterRd = '0;
    ID_Ctrl = '0; ID_ReadData1 = '0; ID_ReadData2 = '0; ID_SignExtImm = '0;
    #3;
    checkEx("reset0");
    check("reset0.pcwrite", 64'(PCWrite), 64'd1);
    @(negedge clk) rst_n = 1'b1;

    // Pass-through
    step("pass", 1'b0, 5'd2, 5'd3, 5'd4, 9'h182, 32'hA5A5_0001, 32'h1234_5678, 32'hFFFF_FFF0);

    // Load-use: lw $5 then consumer of $5, then held instruction re-presented
    step("lw5", 1'b0, 5'd1, 5'd5, 5'd0, LW_CTRL, 32'h10, 32'h20, 32'h4);
    check("lw5.memread_in_ex", 64'(ID_EX_MemRead), 64'd1);
    step("use5", 1'b0, 5'd5, 5'd6, 5'd7, 9'h182, 32'hAA, 32'hBB, 32'h0);
    check("use5.stallcount", 64'(StallCount), 64'd1);
    step("use5held", 1'b0, 5'd5, 5'd6, 5'd7, 9'h182, 32'hAA, 32'hBB, 32'h0);
    check("use5held.rs", 64'(ID_EX_RegisterRs), 64'd5);

    // lw to $0 never stalls
    step("lw0", 1'b0, 5'd1, 5'd0, 5'd0, LW_CTRL, 32'h1, 32'h2, 32'h3);
    step("use0", 1'b0, 5'd0, 5'd0, 5'd9, 9'h182, 32'h5, 32'h6, 32'h7);

    // Flush and stall in the same cycle
    step("lw8", 1'b0, 5'd2, 5'd8, 5'd0, LW_CTRL, 32'h11, 32'h22, 32'h33);
    step("flushuse8", 1'b1, 5'd8, 5'd8, 5'd3, 9'h182, 32'h44, 32'h55, 32'h66);

    // Asynchronous reset mid-cycle with live contents
    step("preReset", 1'b0, 5'd4, 5'd9, 5'd10, 9'h1FF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    exModel = '0; stallModel = 0;
    checkEx("asyncReset");
    check("asyncReset.pcwrite", 64'(PCWrite), 64'd1);
    check("asyncReset.ifidwrite", 64'(IF_ID_Write), 64'd1);
    @(negedge clk) rst_n = 1'b1;

    // Saturation: 17 load-use pairs, counter must stop at all-ones
    for (int i = 0; i < 17; i++) begin
      step("satLw", 1'b0, 5'd1, 5'd7, 5'd0, LW_CTRL, 32'(i), 32'h0, 32'h0);
      step("satUse", 1'b0, 5'd7, 5'd2, 5'd3, 9'h182, 32'h0, 32'(i), 32'h0);
    end
    check("saturated", 64'(StallCount), 64'hF);

    // Random streams over a small register range so hazards are frequent
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           9'($urandom), $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
